// File: rtl/irda_fir_4ppm_tx_pkg.sv
// Shared definitions for the FIR 4PPM transmitter: state encodings, chip timing default,
// 4PPM symbol table and the preamble chip pattern.
package irda_fir_4ppm_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DATA     = 2'd1,
      ST_PREAMBLE = 2'd2
   } fir_state_e;

   localparam int TICKS_PER_CHIP_DEF = 5;
   localparam int PREAMBLE_REPS_DEF  = 16;

   localparam logic [3:0] PPM_SYM_00 = 4'b1000;
   localparam logic [3:0] PPM_SYM_01 = 4'b0100;
   localparam logic [3:0] PPM_SYM_10 = 4'b0010;
   localparam logic [3:0] PPM_SYM_11 = 4'b0001;

   localparam logic [15:0] PREAMBLE_PATTERN = 16'b1000000010101000;

   // Chip 0 is the leftmost (MSB) chip of a symbol, i.e. the first one on the line.
   function automatic logic ppm_chip(input logic [1:0] dibit, input logic [1:0] chip);
      logic [3:0] sym;
      case (dibit)
         2'd0:    sym = PPM_SYM_00;
         2'd1:    sym = PPM_SYM_01;
         2'd2:    sym = PPM_SYM_10;
         default: sym = PPM_SYM_11;
      endcase
      return sym[2'd3 - chip];
   endfunction

   function automatic logic preamble_chip(input logic [3:0] idx);
      return PREAMBLE_PATTERN[4'd15 - idx];
   endfunction

endpackage

// File: rtl/irda_fir_4ppm_tx_chip_timer.sv
// Chip timer: tick counter within a chip and chip counter within a 4-chip symbol,
// both advancing only on fast_enable, with a synchronous clear while the transmitter idles.
module irda_fir_chip_timer #(
   parameter int TICKS_PER_CHIP = 5
) (
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic       fast_enable,
   input  logic       clear,
   output logic [1:0] chip_idx,
   output logic       chip_end,
   output logic       symbol_end
);

   localparam int TW = (TICKS_PER_CHIP > 1) ? $clog2(TICKS_PER_CHIP) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_CHIP - 1);

   logic [TW-1:0] tick_cnt;

   assign chip_end   = !clear && (tick_cnt == TICK_LAST);
   assign symbol_end = chip_end && (chip_idx == 2'd3);

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tick_cnt <= '0;
         chip_idx <= '0;
      end else if (fast_enable) begin
         if (clear) begin
            tick_cnt <= '0;
            chip_idx <= '0;
         end else if (chip_end) begin
            tick_cnt <= '0;
            chip_idx <= chip_idx + 2'd1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/irda_fir_4ppm_tx.sv
// FIR 4 Mb/s transmit chip generator: bytes in over valid/ready, 4PPM chips out, one chip
// per TICKS_PER_CHIP fast_enable ticks. Define IRDA_FIR_TX_PREAMBLE_EN to add the preamble.
module irda_fir_4ppm_tx
   import irda_fir_4ppm_tx_pkg::*;
#(
   parameter int TICKS_PER_CHIP = TICKS_PER_CHIP_DEF
`ifdef IRDA_FIR_TX_PREAMBLE_EN
   ,
   parameter int PREAMBLE_REPS = PREAMBLE_REPS_DEF
`endif
) (
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic       fast_enable,
   input  logic       tx_enable,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       underrun_o
);

   fir_state_e state, state_next;
   logic [7:0] hold_data, shift_data;
   logic       hold_full;
   logic [1:0] dibit_idx, chip_idx;
   logic [1:0] cur_dibit, next_dibit;
   logic       chip_end, symbol_end, byte_end;
   logic       accept, load, seg_end, tx_next, underrun_next;

   assign accept       = data_valid_i && !hold_full;
   assign data_ready_o = !hold_full;
   assign busy_o       = (state != ST_IDLE);
   assign byte_end     = symbol_end && (dibit_idx == 2'd3);
   assign cur_dibit    = shift_data[{dibit_idx, 1'b0} +: 2];
   assign next_dibit   = shift_data[{dibit_idx + 2'd1, 1'b0} +: 2];

   irda_fir_chip_timer #(
      .TICKS_PER_CHIP(TICKS_PER_CHIP)
   ) u_timer (
      .clk        (clk),
      .wb_rst_i   (wb_rst_i),
      .fast_enable(fast_enable),
      .clear      (state == ST_IDLE),
      .chip_idx   (chip_idx),
      .chip_end   (chip_end),
      .symbol_end (symbol_end)
   );

`ifdef IRDA_FIR_TX_PREAMBLE_EN
   localparam int RW = (PREAMBLE_REPS > 1) ? $clog2(PREAMBLE_REPS) : 1;
   logic [RW-1:0] rep_cnt;
   logic          pre_end;

   // dibit_idx doubles as the 4-chip group index inside one 16-chip preamble repetition.
   assign pre_end = byte_end && (rep_cnt == RW'(PREAMBLE_REPS - 1));

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i)
         rep_cnt <= '0;
      else if (fast_enable) begin
         if (state != ST_PREAMBLE)
            rep_cnt <= '0;
         else if (byte_end)
            rep_cnt <= rep_cnt + 1'b1;
      end
   end
`endif

   // A segment (byte or preamble) ending either chains straight into the held byte or drops to idle.
   always_comb begin
      state_next    = state;
      load          = 1'b0;
      seg_end       = 1'b0;
      tx_next       = tx_o;
      underrun_next = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_next = 1'b0;
`ifdef IRDA_FIR_TX_PREAMBLE_EN
            if (tx_enable) begin
               state_next = ST_PREAMBLE;
               tx_next    = preamble_chip(4'd0);
            end
`else
            if (tx_enable && hold_full) begin
               state_next = ST_DATA;
               load       = 1'b1;
               tx_next    = ppm_chip(hold_data[1:0], 2'd0);
            end
`endif
         end
         ST_DATA: begin
            if (chip_end) begin
               if (byte_end)
                  seg_end = 1'b1;
               else if (chip_idx == 2'd3)
                  tx_next = ppm_chip(next_dibit, 2'd0);
               else
                  tx_next = ppm_chip(cur_dibit, chip_idx + 2'd1);
            end
         end
`ifdef IRDA_FIR_TX_PREAMBLE_EN
         ST_PREAMBLE: begin
            if (chip_end) begin
               if (pre_end)
                  seg_end = 1'b1;
               else
                  tx_next = preamble_chip({dibit_idx, chip_idx} + 4'd1);
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
      if (seg_end) begin
         if (hold_full) begin
            state_next = ST_DATA;
            load       = 1'b1;
            tx_next    = ppm_chip(hold_data[1:0], 2'd0);
         end else begin
            state_next    = ST_IDLE;
            tx_next       = 1'b0;
            underrun_next = tx_enable;
         end
      end
   end

   // The handshake is the only thing allowed to move between fast_enable ticks.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_data <= data_i;
         hold_full <= 1'b1;
      end else if (fast_enable && load) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= ST_IDLE;
         tx_o       <= 1'b0;
         underrun_o <= 1'b0;
         shift_data <= '0;
         dibit_idx  <= '0;
      end else begin
         underrun_o <= fast_enable && underrun_next;
         if (fast_enable) begin
            state <= state_next;
            tx_o  <= tx_next;
            if (load)
               shift_data <= hold_data;
            if (state == ST_IDLE)
               dibit_idx <= '0;
            else if (symbol_end)
               dibit_idx <= dibit_idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_irda_fir_4ppm_tx.sv
// Self-checking bench for irda_fir_4ppm_tx: directed byte streams plus random bytes and
// random fast_enable spacing, checked tick by tick against a chip-stream reference model.
module tb_irda_fir_4ppm_tx;

`ifdef IRDA_FIR_TX_PREAMBLE_EN
   localparam int PRE_TICKS = 16 * 16 * 5;
`else
   localparam int PRE_TICKS = 0;
`endif

   logic       clk = 1'b0;
   logic       wb_rst_i;
   logic       fast_enable;
   logic       tx_enable;
   logic [7:0] data_i;
   logic       data_valid_i;
   logic       data_ready_o;
   logic       tx_o;
   logic       busy_o;
   logic       underrun_o;

   int total = 0;
   int bad   = 0;

   logic [7:0]  feed[$];
   logic [7:0]  stream_bytes[$];
   logic [15:0] pre_pat = 16'b1000000010101000;

   always #5 clk = ~clk;

   irda_fir_4ppm_tx dut (
      .clk         (clk),
      .wb_rst_i    (wb_rst_i),
      .fast_enable (fast_enable),
      .tx_enable   (tx_enable),
      .data_i      (data_i),
      .data_valid_i(data_valid_i),
      .data_ready_o(data_ready_o),
      .tx_o        (tx_o),
      .busy_o      (busy_o),
      .underrun_o  (underrun_o)
   );

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Expected line level at stream tick n, counted from the tick that leaves idle.
   function automatic logic exp_chip(input int n);
      int m, b, k, dibit;
      if (n < PRE_TICKS) begin
         k = (n / 5) % 16;
         return pre_pat[15 - k];
      end
      m     = n - PRE_TICKS;
      b     = int'(stream_bytes[m / 80]);
      k     = (m % 80) / 5;
      dibit = (b >> (2 * (k / 4))) & 3;
      return ((k % 4) == dibit);
   endfunction

   task automatic apply_stimulus(input logic fe);
      logic take;
      @(negedge clk);
      fast_enable = fe;
      if (feed.size() > 0) begin
         data_i       = feed[0];
         data_valid_i = 1'b1;
      end else begin
         data_valid_i = 1'b0;
      end
      take = data_valid_i && data_ready_o;
      @(posedge clk);
      #1;
      if (take)
         void'(feed.pop_front());
   endtask

   task automatic tick();
      repeat ($urandom_range(0, 4)) apply_stimulus(1'b0);
      apply_stimulus(1'b1);
   endtask

   task automatic prime_stream();
      feed = stream_bytes;
      apply_stimulus(1'b0);
      apply_stimulus(1'b0);
      check_output("ready low after accept", data_ready_o, 1'b0);
      tx_enable = 1'b1;
   endtask

   task automatic run_stream(input int drop_at, input logic exp_under);
      int len;
      prime_stream();
      len = PRE_TICKS + 80 * stream_bytes.size();
      for (int n = 0; n < len; n++) begin
         if (n == drop_at)
            tx_enable = 1'b0;
         tick();
         check_output($sformatf("tx n=%0d", n), tx_o, exp_chip(n));
         check_output($sformatf("busy n=%0d", n), busy_o, 1'b1);
         check_output($sformatf("underrun n=%0d", n), underrun_o, 1'b0);
      end
      tick();
      check_output("tx at end", tx_o, 1'b0);
      check_output("busy at end", busy_o, 1'b0);
      check_output("underrun at end", underrun_o, exp_under);
      check_output("ready at end", data_ready_o, 1'b1);
      apply_stimulus(1'b0);
      check_output("underrun one clk", underrun_o, 1'b0);
      tx_enable = 1'b0;
   endtask

   initial begin
      logic [7:0] r1, r2;
      int target;
      wb_rst_i     = 1'b1;
      fast_enable  = 1'b0;
      tx_enable    = 1'b0;
      data_valid_i = 1'b0;
      data_i       = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset tx", tx_o, 1'b0);
      check_output("reset busy", busy_o, 1'b0);
      check_output("reset underrun", underrun_o, 1'b0);
      check_output("reset ready", data_ready_o, 1'b1);
      @(negedge clk);
      wb_rst_i = 1'b0;

      $display("[TB] single byte 0xE4 with underrun");
      stream_bytes.delete();
      stream_bytes.push_back(8'hE4);
      run_stream(-1, 1'b1);

      $display("[TB] back-to-back 0x00 0xFF");
      stream_bytes.delete();
      stream_bytes.push_back(8'h00);
      stream_bytes.push_back(8'hFF);
      run_stream(-1, 1'b1);

      $display("[TB] tx_enable dropped mid-byte with a byte held");
      stream_bytes.delete();
      stream_bytes.push_back(8'h1B);
      stream_bytes.push_back(8'h55);
      run_stream(PRE_TICKS + 30, 1'b0);

      $display("[TB] reset while tx_o is high");
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      stream_bytes.delete();
      stream_bytes.push_back(r1);
      stream_bytes.push_back(r2);
      prime_stream();
      target = PRE_TICKS + 5 * int'(r1[1:0]) + 2;
      for (int n = 0; n <= target; n++) begin
         tick();
         check_output($sformatf("pre-reset tx n=%0d", n), tx_o, exp_chip(n));
      end
      check_output("pre-reset tx high", tx_o, 1'b1);
      @(negedge clk);
      #2 wb_rst_i = 1'b1;
      #1;
      check_output("async reset tx", tx_o, 1'b0);
      check_output("async reset ready", data_ready_o, 1'b1);
      check_output("async reset busy", busy_o, 1'b0);
      feed.delete();
      data_valid_i = 1'b0;
      tx_enable    = 1'b0;
      @(negedge clk);
      wb_rst_i = 1'b0;

      $display("[TB] clean restart after reset");
      stream_bytes.delete();
      stream_bytes.push_back(8'($urandom));
      run_stream(-1, 1'b1);

      $display("[TB] random three-byte stream");
      stream_bytes.delete();
      repeat (3) stream_bytes.push_back(8'($urandom));
      run_stream(-1, 1'b1);

      $display("[TB] random byte with quiet stop");
      stream_bytes.delete();
      stream_bytes.push_back(8'($urandom));
      run_stream(PRE_TICKS + int'($urandom_range(1, 79)), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
